// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, mul/div sequencer state encoding, default width.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package alu_pkg;

  // Default datapath width for the ALU and the multi-cycle sequencer
  localparam int MULDIV_WIDTH = 32;

  // ALU opcodes; DIV and MUL are the multi-cycle ones handled by muldiv_seq_ctrl
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_DIV = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b0110;
  localparam logic [3:0] OP_SLL = 4'b0111;
  localparam logic [3:0] OP_SRL = 4'b1000;
  localparam logic [3:0] OP_SRA = 4'b1001;
  localparam logic [3:0] OP_ROR = 4'b1010;
  localparam logic [3:0] OP_ROL = 4'b1011;

  // Iteration step mode select
  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

  // Sequencer state encoding
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MUL_IT = 3'd1,
    S_DIV_IT = 3'd2,
    S_FIX    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One combinational mul/div iteration: Booth add/sub + arithmetic shift, or restoring divide step.
// Latency: combinational, 0 cycles.
// Backpressure: none; the controller registers the result every iteration cycle.
module muldiv_step
  import alu_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic               mode,        // MODE_MUL or MODE_DIV
  input  logic [2*WIDTH:0]   acc,         // MUL: {A[W:0], multiplier bits}; DIV: {R[W:0], Q}
  input  logic [WIDTH:0]     operand,     // MUL: sign-extended multiplicand; DIV: |divisor|
  input  logic [1:0]         booth_pair,  // {b[i], b[i-1]}
  output logic [2*WIDTH:0]   acc_nxt,
  output logic               q_bit        // DIV: new quotient bit; MUL: bit shifted out (next b[i-1])
);

  logic [WIDTH:0]   upper;
  logic [WIDTH:0]   sum;
  logic [2*WIDTH:0] shifted;
  logic [WIDTH+1:0] trial;

  // Upper half is one bit wider than WIDTH so partial sums with -2^(W-1) and remainders up to 2^W never overflow
  always_comb begin
    upper   = acc[2*WIDTH:WIDTH];
    sum     = upper;
    shifted = {acc[2*WIDTH-1:0], 1'b0};
    trial   = {1'b0, shifted[2*WIDTH:WIDTH]} - {1'b0, operand};
    acc_nxt = acc;
    q_bit   = 1'b0;
    if (mode == MODE_DIV) begin
      // Borrow out of the trial subtraction means the shifted remainder was smaller than |b|
      if (!trial[WIDTH+1]) begin
        acc_nxt = {trial[WIDTH:0], shifted[WIDTH-1:1], 1'b1};
        q_bit   = 1'b1;
      end else begin
        acc_nxt = shifted;
        q_bit   = 1'b0;
      end
    end else begin
      case (booth_pair)
        2'b10:   sum = upper - operand;
        2'b01:   sum = upper + operand;
        default: sum = upper;
      endcase
      acc_nxt = {sum[WIDTH], sum, acc[WIDTH-1:1]};
      q_bit   = acc[0];
    end
  end

endmodule

// File: rtl/muldiv_seq_ctrl.sv
// Multi-cycle signed MUL (radix-2 Booth) / DIV (restoring) sequencer feeding the HI/LO pair.
// Latency: done WIDTH+2 cycles after start is accepted; divide-by-zero done the next cycle.
// Backpressure: start is only sampled in IDLE; starts while busy are dropped. Optional MULDIV_ILLEGAL_OP_EN flags illegal ops.
module muldiv_seq_ctrl
  import alu_pkg::*;
#(
  parameter int         WIDTH  = MULDIV_WIDTH,
  parameter logic [3:0] OP_DIV = alu_pkg::OP_DIV,
  parameter logic [3:0] OP_MUL = alu_pkg::OP_MUL
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             err
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH:0]   acc_q;
  logic [WIDTH:0]     opnd_q;
  logic               prev_q;
  logic               is_div_q;
  logic               neg_quo_q;
  logic               neg_rem_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               err_q;

  logic               b_zero;
  logic               mul_req, div_req, illegal_req;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [2*WIDTH:0]   step_acc;
  logic               step_q;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  assign b_zero      = (b == '0);
  assign mul_req     = (state_q == S_IDLE) && start && (op == OP_MUL);
  assign div_req     = (state_q == S_IDLE) && start && (op == OP_DIV);
  assign illegal_req = (state_q == S_IDLE) && start && (op != OP_MUL) && (op != OP_DIV);
  // Magnitudes are unsigned, so -2^(W-1) maps cleanly to 2^(W-1)
  assign abs_a       = a[WIDTH-1] ? -a : a;
  assign abs_b       = b[WIDTH-1] ? -b : b;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .mode       (is_div_q ? MODE_DIV : MODE_MUL),
    .acc        (acc_q),
    .operand    (opnd_q),
    .booth_pair ({acc_q[0], prev_q}),
    .acc_nxt    (step_acc),
    .q_bit      (step_q)
  );

  // Sign fix-up: quotient negative when operand signs differ, remainder follows the dividend
  always_comb begin
    fix_hi = acc_q[2*WIDTH-1:WIDTH];
    fix_lo = acc_q[WIDTH-1:0];
    if (is_div_q) begin
      if (neg_rem_q) fix_hi = -acc_q[2*WIDTH-1:WIDTH];
      if (neg_quo_q) fix_lo = -acc_q[WIDTH-1:0];
    end
  end

  // State register
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic: WIDTH iterations, one fix-up cycle, one done cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op == OP_MUL)      state_d = S_MUL_IT;
          else if (op == OP_DIV) state_d = b_zero ? S_DONE : S_DIV_IT;
`ifdef MULDIV_ILLEGAL_OP_EN
          else                   state_d = S_DONE;
`endif
        end
      end
      S_MUL_IT, S_DIV_IT: begin
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result registers
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      prev_q    <= 1'b0;
      is_div_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      err_q     <= 1'b0;
    end else if (mul_req) begin
      acc_q    <= {{(WIDTH + 1){1'b0}}, b};
      opnd_q   <= {a[WIDTH-1], a};
      prev_q   <= 1'b0;
      is_div_q <= 1'b0;
      cnt_q    <= '0;
    end else if (div_req) begin
      acc_q     <= {{(WIDTH + 1){1'b0}}, abs_a};
      opnd_q    <= {1'b0, abs_b};
      prev_q    <= 1'b0;
      is_div_q  <= 1'b1;
      neg_quo_q <= a[WIDTH-1] ^ b[WIDTH-1];
      neg_rem_q <= a[WIDTH-1];
      cnt_q     <= '0;
      // Divide-by-zero skips the iterations and reports straight away
      if (b_zero) begin
        hi_q  <= a;
        lo_q  <= '1;
        err_q <= 1'b1;
      end
    end else if ((state_q == S_MUL_IT) || (state_q == S_DIV_IT)) begin
      acc_q  <= step_acc;
      prev_q <= step_q;
      cnt_q  <= cnt_q + CNT_W'(1);
    end else if (state_q == S_FIX) begin
      hi_q  <= fix_hi;
      lo_q  <= fix_lo;
      err_q <= 1'b0;
`ifdef MULDIV_ILLEGAL_OP_EN
    end else if (illegal_req) begin
      err_q <= 1'b1;
`endif
    end
  end

`ifndef MULDIV_ILLEGAL_OP_EN
  // Illegal opcodes are simply ignored in this build
  logic unused_illegal;
  assign unused_illegal = illegal_req;
`endif

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;
  assign err  = err_q;

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Self-checking bench for muldiv_seq_ctrl: directed corner cases plus randomized MUL/DIV against an arithmetic model.
// Latency: n/a.
// Backpressure: n/a.
module tb_muldiv_seq_ctrl;

  localparam int         W      = 32;
  localparam logic [3:0] T_DIV  = 4'b0010;
  localparam logic [3:0] T_MUL  = 4'b0011;

  logic          clock   = 1'b0;
  logic          clear_n = 1'b0;
  logic          start   = 1'b0;
  logic [3:0]    op      = 4'd0;
  logic [W-1:0]  a       = '0;
  logic [W-1:0]  b       = '0;
  logic          busy, done, err;
  logic [W-1:0]  hi, lo;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] last_hi = '0;
  logic [W-1:0] last_lo = '0;

  muldiv_seq_ctrl dut (
    .clock   (clock),
    .clear_n (clear_n),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo),
    .err     (err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed 64-bit arithmetic; SV division truncates toward zero and % follows the dividend
  function automatic void model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] eh, output logic [W-1:0] el, output logic ee);
    logic signed [63:0] sx, sy, p, q, r;
    sx = {{32{x[W-1]}}, x};
    sy = {{32{y[W-1]}}, y};
    ee = 1'b0;
    if (o == T_MUL) begin
      p  = sx * sy;
      eh = p[63:32];
      el = p[31:0];
    end else if (y == '0) begin
      ee = 1'b1;
      eh = x;
      el = '1;
    end else begin
      q  = sx / sy;
      r  = sx % sy;
      eh = r[31:0];
      el = q[31:0];
    end
  endfunction

  task automatic run_op(input string tag, input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] eh, el;
    logic         ee;
    int           lat, exp_lat;
    model(o, x, y, eh, el, ee);
    exp_lat = (o == T_DIV && y == '0) ? 1 : W + 2;
    @(negedge clock);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clock);
    start = 1'b0; op = 4'($urandom); a = $urandom; b = $urandom;
    lat = 1;
    check({tag, " busy_after_accept"}, 64'(busy), 64'(1));
    while (done !== 1'b1 && lat < 80) begin
      @(negedge clock);
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " hi"}, 64'(hi), 64'(eh));
    check({tag, " lo"}, 64'(lo), 64'(el));
    check({tag, " err"}, 64'(err), 64'(ee));
    last_hi = eh;
    last_lo = el;
    @(negedge clock);
    check({tag, " done_pulse"}, 64'(done), 64'(0));
    check({tag, " idle_busy"}, 64'(busy), 64'(0));
  endtask

  initial begin
    int ndone, first_done, lat2, busy_seen;
    logic [3:0]   ro;
    logic [W-1:0] rx, ry;

    // Reset state
    #1;
    check("rst busy", 64'(busy), 64'(0));
    check("rst done", 64'(done), 64'(0));
    check("rst hi",   64'(hi),   64'(0));
    check("rst lo",   64'(lo),   64'(0));
    check("rst err",  64'(err),  64'(0));
    @(negedge clock);
    @(negedge clock);
    clear_n = 1'b1;

    // Directed cases
    run_op("mul_7_m3", T_MUL, 32'd7, 32'hFFFF_FFFD);
    run_op("div_m17_5", T_DIV, 32'hFFFF_FFEF, 32'd5);
    run_op("div_9_0", T_DIV, 32'd9, 32'd0);
    run_op("div_min_m1", T_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("mul_min_min", T_MUL, 32'h8000_0000, 32'h8000_0000);

    // Start while busy is dropped; start in the done cycle is accepted on the following IDLE edge
    @(negedge clock);
    start = 1'b1; op = T_MUL; a = 32'd7; b = 32'hFFFF_FFFD;
    @(negedge clock);
    start = 1'b0;
    ndone = 0;
    first_done = 0;
    for (int k = 1; k <= W + 2; k++) begin
      if (k > 1) @(negedge clock);
      if (done === 1'b1) begin
        ndone++;
        first_done = k;
      end
      start = (k == 5) || (k == W + 2);
      if (k == 5)     begin op = T_DIV; a = 32'd100; b = 32'd3; end
      if (k == W + 2) begin op = T_DIV; a = 32'hFFFF_FFEF; b = 32'd5; end
    end
    check("busy_ign ndone", 64'(ndone), 64'(1));
    check("busy_ign when", 64'(first_done), 64'(W + 2));
    check("busy_ign hi", 64'(hi), 64'(32'hFFFF_FFFF));
    check("busy_ign lo", 64'(lo), 64'(32'hFFFF_FFEB));
    check("busy_ign err", 64'(err), 64'(0));
    lat2 = 0;
    do begin
      @(negedge clock);
      lat2++;
      if (lat2 == 2) start = 1'b0;
    end while (done !== 1'b1 && lat2 < 80);
    start = 1'b0;
    check("b2b spacing", 64'(lat2), 64'(W + 3));
    check("b2b hi", 64'(hi), 64'(32'hFFFF_FFFE));
    check("b2b lo", 64'(lo), 64'(32'hFFFF_FFFD));
    check("b2b err", 64'(err), 64'(0));
    @(negedge clock);
    check("b2b done_pulse", 64'(done), 64'(0));

    // Reset in the middle of a divide
    @(negedge clock);
    start = 1'b1; op = T_DIV; a = 32'd1000; b = 32'd7;
    @(negedge clock);
    start = 1'b0;
    for (int k = 2; k <= 10; k++) @(negedge clock);
    clear_n = 1'b0;
    #1;
    check("midrst busy", 64'(busy), 64'(0));
    check("midrst done", 64'(done), 64'(0));
    check("midrst hi",   64'(hi),   64'(0));
    check("midrst lo",   64'(lo),   64'(0));
    check("midrst err",  64'(err),  64'(0));
    @(negedge clock);
    clear_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (done === 1'b1) ndone++;
    end
    check("midrst no_done", 64'(ndone), 64'(0));
    run_op("mul_min_m1", T_MUL, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("mul_m5_9", T_MUL, 32'hFFFF_FFFB, 32'd9);

    // Illegal opcode
    @(negedge clock);
    start = 1'b1; op = 4'b0100; a = 32'h1234_5678; b = 32'd3;
    @(negedge clock);
    start = 1'b0;
`ifdef MULDIV_ILLEGAL_OP_EN
    check("illegal done", 64'(done), 64'(1));
    check("illegal err",  64'(err),  64'(1));
    check("illegal hi",   64'(hi),   64'(last_hi));
    check("illegal lo",   64'(lo),   64'(last_lo));
    @(negedge clock);
    check("illegal done_pulse", 64'(done), 64'(0));
`else
    ndone = 0;
    busy_seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clock);
      if (done === 1'b1) ndone++;
      if (busy === 1'b1) busy_seen++;
    end
    check("illegal no_done", 64'(ndone), 64'(0));
    check("illegal no_busy", 64'(busy_seen), 64'(0));
    check("illegal hi", 64'(hi), 64'(last_hi));
    check("illegal lo", 64'(lo), 64'(last_lo));
    check("illegal err", 64'(err), 64'(0));
`endif

    // Randomized MUL/DIV with weighted corner operands
    for (int i = 0; i < 20; i++) begin
      ro = ($urandom % 2 == 0) ? T_MUL : T_DIV;
      rx = $urandom;
      ry = $urandom;
      case ($urandom % 8)
        0: ry = '0;
        1: rx = 32'h8000_0000;
        2: ry = 32'($urandom % 16) - 32'd8;
        3: ry = 32'hFFFF_FFFF;
        4: rx = 32'($urandom % 64) - 32'd32;
        default: ;
      endcase
      run_op("rand", ro, rx, ry);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
